// File: rtl/execute_stage.sv
// Execute stage: single-cycle logic/shift/arith/move results plus a multi-cycle
// restoring divider that owns the HI/LO registers and holds the pipeline while busy.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   aluop_i, alusel_i  operation code and result class from ID/EX
//   reg1_i, reg2_i     operands (shift amount is reg1_i[4:0], shifted value reg2_i)
//   wd_i, wreg_i       destination address and write enable from ID/EX
//   wd_o, wreg_o       destination address and write enable to EX/MEM
//   wdata_o            result to EX/MEM
//   stall_req_o        pipeline hold request while the divider is busy
//   hi_o, lo_o         current HI/LO register contents
module execute_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b011;
    localparam logic [2:0] SEL_MOVE  = 3'b100;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } div_state_t;

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      dvd_q;   // dividend shifting out, quotient shifting in
    logic [31:0]      dvs_q;
    logic [31:0]      rem_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic        is_div;
    logic        is_sdiv;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [31:0] step_q;
    logic [31:0] step_r;
    logic        last_step;
    logic        div_busy;
    logic [31:0] result;

    assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv   = (aluop_i == OP_DIV);
    assign abs1      = reg1_i[31] ? 32'(32'd0 - reg1_i) : reg1_i;
    assign abs2      = reg2_i[31] ? 32'(32'd0 - reg2_i) : reg2_i;
    assign last_step = (cnt == CNT_W'(DIV_CYCLES - 1));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // On the restore path the shifted remainder is below 2^32, so 32 bits suffice.
    always_comb begin
        trial = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
        if (!trial[32]) begin
            step_r = trial[31:0];
            step_q = {dvd_q[30:0], 1'b1};
        end else begin
            step_r = {rem_q[30:0], dvd_q[31]};
            step_q = {dvd_q[30:0], 1'b0};
        end
    end

    // Divider FSM and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        cnt   <= '0;
                        rem_q <= '0;
                        if (reg2_i == 32'd0) begin
                            state <= S_DIVZERO;
                        end else begin
                            dvd_q      <= is_sdiv ? abs1 : reg1_i;
                            dvs_q      <= is_sdiv ? abs2 : reg2_i;
                            neg_quot_q <= is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_q  <= is_sdiv && reg1_i[31];
                            state      <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    dvd_q <= '0;
                    rem_q <= '0;
                    state <= S_END;
                end
                S_ON: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        // Signed fixup: quotient negated on sign mismatch, remainder follows dividend.
                        dvd_q <= neg_quot_q ? 32'(32'd0 - step_q) : step_q;
                        rem_q <= neg_rem_q ? 32'(32'd0 - step_r) : step_r;
                        state <= S_END;
                    end else begin
                        dvd_q <= step_q;
                        rem_q <= step_r;
                    end
                end
                S_END: begin
                    hi_q  <= rem_q;
                    lo_q  <= dvd_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Single-cycle result select.
    always_comb begin
        result = 32'd0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  result = reg1_i & reg2_i;
                    OP_OR:   result = reg1_i | reg2_i;
                    OP_XOR:  result = reg1_i ^ reg2_i;
                    OP_NOR:  result = ~(reg1_i | reg2_i);
                    default: result = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result = reg2_i << reg1_i[4:0];
                    OP_SRL:  result = reg2_i >> reg1_i[4:0];
                    OP_SRA:  result = 32'($signed(reg2_i) >>> reg1_i[4:0]);
                    default: result = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADD:  result = reg1_i + reg2_i;
                    OP_SUB:  result = reg1_i - reg2_i;
                    OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    OP_SLTU: result = {31'd0, reg1_i < reg2_i};
                    default: result = 32'd0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: result = hi_q;
                    OP_MFLO: result = lo_q;
                    default: result = 32'd0;
                endcase
            end
            SEL_NOP: result = 32'd0;
            default: result = 32'd0;
        endcase
    end

    // A divide writes only HI/LO, so suppress the GPR write while one is in flight.
    assign div_busy    = (state != S_IDLE) || is_div;
    assign stall_req_o = rst && ((state == S_IDLE && is_div) || state == S_DIVZERO || state == S_ON);
    assign wd_o        = rst ? wd_i : 5'd0;
    assign wreg_o      = rst && wreg_i && !div_busy;
    assign wdata_o     = (rst && !div_busy) ? result : 32'd0;
    assign hi_o        = rst ? hi_q : 32'd0;
    assign lo_o        = rst ? lo_q : 32'd0;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: single-cycle ops, DIV/DIVU timing and results,
// divide-by-zero, and reset in the middle of a divide.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;
    int stalls;

    execute_stage #(.DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stall_req_o(stall_req_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one instruction just after a rising edge, then wait to the sampling edge.
    task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        @(posedge clk);
        #1;
        alusel_i = sel;
        aluop_i  = op;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
        @(negedge clk);
    endtask

    // Issue a divide and count stalled cycles; returns at the sampling point of the release cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int n);
        n = 0;
        issue(3'b000, op, a, b, 5'd9, 1'b1);
        check("div_wreg_suppressed", {31'd0, wreg_o}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (!stall_req_o) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b0;
        alusel_i = 3'b001;
        aluop_i  = 8'h25;
        reg1_i   = 32'h1234_5678;
        reg2_i   = 32'h0F0F_F0F0;
        wd_i     = 5'd7;
        wreg_i   = 1'b1;

        // Reset held for two cycles: every output reads zero.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_wdata", wdata_o, 32'd0);
            check("rst_wreg", {31'd0, wreg_o}, 32'd0);
            check("rst_wd", {27'd0, wd_o}, 32'd0);
            check("rst_stall", {31'd0, stall_req_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(3'b000, 8'h00, 32'hDEAD_BEEF, 32'h1, 5'd3, 1'b1);
        check("post_rst_hi", hi_o, 32'd0);
        check("post_rst_lo", lo_o, 32'd0);
        check("nop_wdata", wdata_o, 32'd0);

        // Single-cycle operations.
        issue(3'b001, 8'h25, 32'h0F0F_0000, 32'h0000_F0F0, 5'd17, 1'b1);
        check("or", wdata_o, 32'h0F0F_F0F0);
        check("or_wd", {27'd0, wd_o}, 32'd17);
        check("or_wreg", {31'd0, wreg_o}, 32'd1);
        issue(3'b001, 8'h24, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2, 1'b0);
        check("and", wdata_o, 32'h0F00_0F00);
        check("and_wreg", {31'd0, wreg_o}, 32'd0);
        issue(3'b001, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd2, 1'b1);
        check("xor", wdata_o, 32'hF0F0_0F0F);
        issue(3'b001, 8'h27, 32'hFFFF_0000, 32'h0000_00FF, 5'd2, 1'b1);
        check("nor", wdata_o, 32'h0000_FF00);
        issue(3'b001, 8'h20, 32'hFFFF_0000, 32'h0000_00FF, 5'd2, 1'b1);
        check("logic_unlisted", wdata_o, 32'd0);
        issue(3'b011, 8'h22, 32'd5, 32'd7, 5'd4, 1'b1);
        check("sub", wdata_o, 32'hFFFF_FFFE);
        issue(3'b011, 8'h20, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1);
        check("add_wrap", wdata_o, 32'd1);
        issue(3'b011, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        check("slt", wdata_o, 32'd1);
        issue(3'b011, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        check("sltu", wdata_o, 32'd0);
        issue(3'b010, 8'h03, 32'd4, 32'h8000_0000, 5'd5, 1'b1);
        check("sra", wdata_o, 32'hF800_0000);
        issue(3'b010, 8'h02, 32'd4, 32'h8000_0000, 5'd5, 1'b1);
        check("srl", wdata_o, 32'h0800_0000);
        issue(3'b010, 8'h7C, 32'd31, 32'd1, 5'd5, 1'b1);
        check("sll", wdata_o, 32'h8000_0000);

        // DIVU 100/7 = 14 remainder 2.
        run_div(8'h1B, 32'd100, 32'd7, stalls);
        check("divu_stalls", 32'(stalls), 32'd33);
        issue(3'b100, 8'h12, 32'd0, 32'd0, 5'd8, 1'b1);
        check("divu_hi", hi_o, 32'd2);
        check("divu_lo", lo_o, 32'd14);
        check("mflo", wdata_o, 32'd14);
        issue(3'b100, 8'h10, 32'd0, 32'd0, 5'd8, 1'b1);
        check("mfhi", wdata_o, 32'd2);

        // DIV -7/2 = -3 remainder -1.
        run_div(8'h1A, 32'hFFFF_FFF9, 32'd2, stalls);
        check("div_stalls", 32'(stalls), 32'd33);
        issue(3'b000, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        // Reset in the tenth ON cycle of a divide.
        issue(3'b000, 8'h1B, 32'd50, 32'd3, 5'd1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("mid_stall_before", {31'd0, stall_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        aluop_i = 8'h00;
        @(negedge clk);
        check("mid_rst_idle", {31'd0, stall_req_o}, 32'd0);
        check("mid_rst_hi", hi_o, 32'd0);
        check("mid_rst_lo", lo_o, 32'd0);

        run_div(8'h1B, 32'd8, 32'd2, stalls);
        check("divu8_stalls", 32'(stalls), 32'd33);
        issue(3'b000, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        check("divu8_lo", lo_o, 32'd4);
        check("divu8_hi", hi_o, 32'd0);

        // Divide by zero: two stall cycles, HI/LO cleared.
        run_div(8'h1A, 32'd9, 32'd0, stalls);
        check("div0_stalls", 32'(stalls), 32'd2);
        issue(3'b000, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        check("div0_hi", hi_o, 32'd0);
        check("div0_lo", lo_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage. Consumer of the ID/EX pipeline register outputs: aluop, alusel, both operands, destination address and write flag.
- Computes single-cycle logic, shift and arithmetic results combinationally.
- Runs a multi-cycle radix-2 divider FSM that stalls the pipeline while busy.
- Owns the HI/LO registers; DIV/DIVU write them and MFHI/MFLO read them. Results feed the EX/MEM register.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles the divider spends in state ON (one quotient bit per cycle).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- aluop_i  input  8  operation code from ID/EX.
- alusel_i  input  3  result class from ID/EX.
- reg1_i  input  32  operand 1.
- reg2_i  input  32  operand 2.
- wd_i  input  5  destination register address.
- wreg_i  input  1  register write enable.
- wd_o  output  5  destination address to EX/MEM.
- wreg_o  output  1  register write enable to EX/MEM.
- wdata_o  output  32  result to EX/MEM.
- stall_req_o  output  1  request pipeline hold while the divider is busy.
- hi_o  output  32  current HI register value.
- lo_o  output  32  current LO register value.

Behaviour:
- Reset (rst==0 at a clock edge):
  - FSM goes to IDLE; HI, LO, divider datapath and counter are cleared.
  - While rst==0, all outputs read 0.
- Encodings. alusel_i:
  - 000 NOP: wdata_o=0.
  - 001 LOGIC
  - 010 SHIFT
  - 011 ARITH
  - 100 MOVE
- Encodings. aluop_i:
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x7C SLL, 0x02 SRL, 0x03 SRA; shift amount is reg1_i[4:0], value is reg2_i.
  - 0x20 ADD, 0x22 SUB, 0x2A SLT (signed), 0x2B SLTU; ADD and SUB wrap modulo 2^32 with no overflow trap.
  - 0x10 MFHI, 0x12 MFLO
  - 0x1A DIV, 0x1B DIVU
  - Any unlisted aluop within a class gives wdata_o=0.
- Single-cycle ops are combinational with zero latency: wd_o=wd_i, wreg_o=wreg_i, wdata_o=result.
- Divider FSM states are IDLE, DIVZERO, ON and END.
- IDLE:
  - On aluop_i DIV or DIVU: stall_req_o=1.
  - If reg2_i==0, next state is DIVZERO.
  - Otherwise latch the operands and go to ON.
  - For DIV, the operands are latched as absolute values, together with the two sign bits.
- DIVZERO: stall_req_o=1; quotient=0, remainder=0; next state END.
- ON:
  - stall_req_o=1; one restoring shift-subtract step per cycle; counter increments.
  - After DIV_CYCLES cycles, go to END.
  - Signed fixup on entry to END: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
- END:
  - stall_req_o=0.
  - At the clock edge: HI<=remainder, LO<=quotient, then go to IDLE.
  - Upstream advances on the same edge, so the same DIV is never restarted.
- Total DIV/DIVU latency:
  - Nonzero divisor: DIV_CYCLES+2 cycles from issue to release, i.e. 34 cycles with stall_req_o=1 for the first 33.
  - Zero divisor: 3 cycles.
- During a divide:
  - wreg_o=0 and wdata_o=0 (DIV writes only HI/LO).
  - Input changes are ignored, because the pipeline is held.
- MFHI/MFLO:
  - Return the HI/LO register contents at issue.
  - An MFHI/MFLO following a DIV sees the new value, because HI/LO update at the END edge before the next instruction enters.
- Reset mid-divide: FSM returns to IDLE, stall_req_o=0 immediately (combinational on rst), and HI/LO are cleared.

Test Plan:
- Reset: hold rst=0 for 2 cycles with arbitrary inputs -> all outputs 0; after release, hi_o=lo_o=0.
- Logic/arith:
  - OR 0x0F0F0000|0x0000F0F0 -> wdata_o=0x0F0FF0F0.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU of the same operands -> 0.
  - wd_o and wreg_o pass through unchanged.
- Shift: SRA with amount 4 on 0x80000000 -> 0xF8000000; SLL with amount 31 on 1 -> 0x80000000.
- DIVU 100/7:
  - stall_req_o high for exactly 33 cycles.
  - Then hi_o=2, lo_o=14.
  - A following MFLO returns 14.
- Signed and zero cases:
  - DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
  - DIV 9/0 -> stall for 2 cycles, then hi_o=lo_o=0.
- Reset mid-divide: assert rst=0 at cycle 10 of ON -> stall_req_o drops, FSM is IDLE, hi_o=lo_o=0; a subsequent DIVU 8/2 completes with lo_o=4.
